// File: rtl/snake_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : snake_input_ctrl
//  Purpose  : Synchronizes, debounces and edge-detects five raw push-buttons
//             (four directions plus start). Produces the snake direction,
//             a one-cycle start pulse and a one-deep turn queue that rejects
//             180-degree reversals.
//  Revision : 1.0  initial release
// ============================================================================
module snake_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,        // asynchronous, active-low
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_start,
  input  logic       move_enable,
  output logic [1:0] direction,
  output logic       start,
  output logic       pending
);

  localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int               N_BTN     = 5;
  localparam int               IDX_START = 4;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       DIR_UP    = 2'b00;
  localparam logic [1:0]       DIR_RIGHT = 2'b01;
  localparam logic [1:0]       DIR_DOWN  = 2'b10;
  localparam logic [1:0]       DIR_LEFT  = 2'b11;

  // Bit order: 0 up, 1 right, 2 down, 3 left, 4 start
  logic [N_BTN-1:0] raw;
  assign raw = {btn_start, btn_left, btn_down, btn_right, btn_up};

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] stable_q;
  logic [N_BTN-1:0] stable_d;
  logic [N_BTN-1:0] stable_dly_q;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];

  logic [N_BTN-1:0] press;
  logic             dir_press;
  logic [1:0]       win_dir;
  logic [1:0]       next_committed;

  logic [1:0]       committed_q;
  logic [1:0]       committed_d;
  logic             req_valid_q;
  logic             req_valid_d;
  logic [1:0]       req_dir_q;
  logic [1:0]       req_dir_d;
  logic             start_q;
  logic             start_d;

  // Two-flop synchronizer on every raw button
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a new level must persist DEBOUNCE_CYCLES cycles to be accepted
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state: accepted level, its one-cycle delay, and hold counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Rising-edge press events and fixed-priority direction winner
  always_comb begin
    press     = stable_q & ~stable_dly_q;
    dir_press = |press[3:0];
    if (press[0]) begin
      win_dir = DIR_UP;
    end else if (press[1]) begin
      win_dir = DIR_RIGHT;
    end else if (press[2]) begin
      win_dir = DIR_DOWN;
    end else begin
      win_dir = DIR_LEFT;
    end
  end

  // A queued turn is visible immediately so the core picks it up on its step
  assign direction = req_valid_q ? req_dir_q : committed_q;

  // Commit on move_enable, then evaluate the new press against the
  // post-commit direction so a reversal of a just-committed turn is caught
  always_comb begin
    next_committed = move_enable ? direction : committed_q;
    committed_d    = next_committed;
    req_valid_d    = move_enable ? 1'b0 : req_valid_q;
    req_dir_d      = req_dir_q;
    start_d        = press[IDX_START];
    if (dir_press) begin
      if (win_dir == (next_committed ^ 2'b10)) begin
        // reversal: ignore, keep whatever is queued
      end else if (win_dir == next_committed) begin
        req_valid_d = 1'b0;
      end else begin
        req_dir_d   = win_dir;
        req_valid_d = 1'b1;
      end
    end
  end

  // Turn queue, committed direction and registered start pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      committed_q <= DIR_RIGHT;
      req_valid_q <= 1'b0;
      req_dir_q   <= DIR_UP;
      start_q     <= 1'b0;
    end else begin
      committed_q <= committed_d;
      req_valid_q <= req_valid_d;
      req_dir_q   <= req_dir_d;
      start_q     <= start_d;
    end
  end

  assign start   = start_q;
  assign pending = req_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snake_input_ctrl
//  Purpose  : Directed self-checking bench for snake_input_ctrl with
//             DEBOUNCE_CYCLES=4 (press visible 6 edges after first sampling).
//  Revision : 1.0  initial release
// ============================================================================
module tb_snake_input_ctrl;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_right, btn_down, btn_left, btn_start;
  logic       move_enable;
  logic [1:0] direction;
  logic       start;
  logic       pending;

  int total = 0;
  int bad   = 0;

  snake_input_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_up      (btn_up),
    .btn_right   (btn_right),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_start   (btn_start),
    .move_enable (move_enable),
    .direction   (direction),
    .start       (start),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step();
    move_enable = 1'b1;
    tick(1);
    move_enable = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    {btn_up, btn_right, btn_down, btn_left, btn_start} = '0;
    move_enable = 1'b0;
    tick(3);
    check_val("rst_dir",     32'(direction), 32'd1);
    check_val("rst_start",   32'(start),     32'd0);
    check_val("rst_pending", 32'(pending),   32'd0);
    reset = 1'b1;
    tick(2);

    // ---- 1: reset mid-run with btn_up bouncing and a turn queued
    btn_up = 1'b1;
    tick(7);
    check_val("pre_rst_pend", 32'(pending), 32'd1);
    btn_up = 1'b0; tick(1); btn_up = 1'b1; tick(1);
    btn_up = 1'b0; tick(1); btn_up = 1'b1; tick(2);
    #2 reset = 1'b0;
    #1;
    check_val("mid_rst_dir",   32'(direction), 32'd1);
    check_val("mid_rst_pend",  32'(pending),   32'd0);
    check_val("mid_rst_start", 32'(start),     32'd0);
    for (int i = 0; i < 5; i++) check_val("mid_rst_cnt", 32'(dut.cnt_q[i]), 32'd0);
    btn_up = 1'b0;
    tick(1);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (pending || start || direction != 2'b01) n++;
    end
    check_val("post_rst_quiet", 32'(n), 32'd0);

    // ---- 2: clean turn up, exact latency, then commit
    btn_up = 1'b1;
    tick(6);
    check_val("up_lat_pend0", 32'(pending),   32'd0);
    check_val("up_lat_dir0",  32'(direction), 32'd1);
    tick(1);
    check_val("up_lat_pend1", 32'(pending),   32'd1);
    check_val("up_lat_dir1",  32'(direction), 32'd0);
    tick(3);
    btn_up = 1'b0;
    tick(8);
    move_enable = 1'b1;
    #1;
    check_val("up_me_dir", 32'(direction), 32'd0);
    tick(1);
    move_enable = 1'b0;
    check_val("up_commit_pend", 32'(pending),         32'd0);
    check_val("up_commit_dir",  32'(direction),       32'd0);
    check_val("up_commit_reg",  32'(dut.committed_q), 32'd0);

    // ---- 3: bounce on btn_right: 3 high, 1 low, 2 high, low
    btn_right = 1'b1; tick(3);
    btn_right = 1'b0; tick(1);
    btn_right = 1'b1; tick(2);
    btn_right = 1'b0; tick(8);
    check_val("bnc_pend", 32'(pending),   32'd0);
    check_val("bnc_dir",  32'(direction), 32'd0);
    for (int i = 0; i < 5; i++) check_val("bnc_cnt", 32'(dut.cnt_q[i]), 32'd0);

    // ---- 4: reversal rejection
    do_reset();
    btn_left = 1'b1; tick(7);
    check_val("rev_left_pend", 32'(pending),   32'd0);
    check_val("rev_left_dir",  32'(direction), 32'd1);
    btn_left = 1'b0; tick(8);
    btn_up = 1'b1; tick(7);
    check_val("rev_up_dir", 32'(direction), 32'd0);
    btn_up = 1'b0; tick(8);
    btn_left = 1'b1; tick(7);
    check_val("rev_left2_dir",  32'(direction), 32'd0);
    check_val("rev_left2_pend", 32'(pending),   32'd1);
    btn_left = 1'b0; tick(8);
    step();
    check_val("rev_commit_reg", 32'(dut.committed_q), 32'd0);
    check_val("rev_commit_pend", 32'(pending),        32'd0);
    btn_left = 1'b1; tick(7);
    check_val("rev_left3_dir",  32'(direction), 32'd3);
    check_val("rev_left3_pend", 32'(pending),   32'd1);
    btn_left = 1'b0; tick(8);

    // ---- 5: simultaneous events
    do_reset();
    btn_up = 1'b1; btn_down = 1'b1; tick(7);
    check_val("sim_prio_dir", 32'(direction), 32'd0);
    btn_up = 1'b0; btn_down = 1'b0; tick(8);
    // down press event is evaluated at the 7th edge, same edge that commits 00
    btn_down = 1'b1; tick(6);
    check_val("sim_pre_pend", 32'(pending), 32'd1);
    step();
    check_val("sim_rev_pend", 32'(pending),         32'd0);
    check_val("sim_rev_dir",  32'(direction),       32'd0);
    check_val("sim_rev_reg",  32'(dut.committed_q), 32'd0);
    btn_down = 1'b0; tick(8);

    // ---- 6: start pulses
    for (int p = 0; p < 2; p++) begin
      btn_start = 1'b1;
      tick(6);
      check_val("start_early", 32'(start), 32'd0);
      tick(1);
      check_val("start_pulse", 32'(start), 32'd1);
      n = 0;
      for (int i = 0; i < 13; i++) begin
        tick(1);
        if (start) n++;
      end
      check_val("start_single", 32'(n), 32'd0);
      btn_start = 1'b0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
        tick(1);
        if (start) n++;
      end
      check_val("start_release", 32'(n), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snake_input_ctrl.md
# snake_input_ctrl

Input conditioner upstream of `snake_game_top`. Takes five raw, asynchronous push-buttons (four directions plus start) and synchronizes, debounces and edge-detects each one. Produces the 2-bit `direction` and a one-cycle `start` pulse consumed by the game core. Queues at most one turn per snake step and rejects 180-degree reversals against the direction the snake last moved in.

## Interface

- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a synchronized input must hold a new level before it is accepted. Legal range ≥ 2. Counter width is `$clog2(DEBOUNCE_CYCLES)+1`.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0). The reset is applied asynchronously and released synchronously by the system.
- `btn_up`, `btn_right`, `btn_down`, `btn_left`  in  1 each  raw buttons, active-high, asynchronous to `clk`, may bounce.
- `btn_start`  in  1  raw start button, active-high, asynchronous.
- `move_enable`  in  1  one-cycle pulse from the game controller in the cycle the snake steps.
- `direction`  out  2  direction to the snake body. Encoding: 00 up, 01 right, 10 down, 11 left. Reverse is `dir ^ 2'b10`.
- `start`  out  1  one-cycle pulse per debounced start press.
- `pending`  out  1  a turn request is queued and not yet committed.

## Operation

- **Reset values (while `reset`=0):**
  - All sync flops, debounced levels and delayed levels are 0; all counters are 0.
  - `committed`=01 (right); `req_valid`=0; `req_dir`=00.
  - Outputs: `direction`=01, `start`=0, `pending`=0.
- **Sync:** two flops per input, giving five synchronized signals `s[i]`.
- **Debounce, per input:**
  - If `s[i]` == `stable[i]`: counter ← 0.
  - Else if counter == `DEBOUNCE_CYCLES`-1: `stable[i]` ← `s[i]`, counter ← 0.
  - Else: counter ← counter+1.
- **Press event:** `press[i]` = `stable[i]` & ~`stable_d[i]`, where `stable_d` is `stable` delayed one cycle. Releases generate no event.
- **Multiple direction presses in one cycle:** priority up > right > down > left. Only the winner is evaluated.
- **Commit:** `direction` = `req_valid` ? `req_dir` : `committed`. This is a combinational mux of registers, so the core sees the queued turn in the same cycle as `move_enable`.
  - On `move_enable`=1: `committed` ← `direction`, `req_valid` ← 0.
  - `next_committed` = `move_enable` ? `direction` : `committed`.
- **Request evaluation** for the winning press `p`, performed after commit in the same cycle:
  - If `p` == `next_committed` ^ 2'b10 (reversal): discard.
  - If `p` == `next_committed` (no-op): discard, and `req_valid` ← 0.
  - Otherwise: `req_dir` ← `p`, `req_valid` ← 1. Last press wins and overwrites any earlier request.
- `pending` = `req_valid`.
- **Start:** `start` is a registered copy of `press[start]`.
- **Button held through reset release:** the debounced level rises after the normal latency and produces one press event. This is intended.
- **Reset mid-operation:** reset clears all state immediately, including partial debounce counts and queued requests.

## Timing

- **Press latency.** Raw input goes high and stays high; edge k is the first edge sampling it high.
  - `s` high after edge k+1.
  - `stable` high after edge k+1+`DEBOUNCE_CYCLES`.
  - `req_valid`/`direction` update after edge k+2+`DEBOUNCE_CYCLES`.
  - `start` is high for exactly the one cycle following edge k+2+`DEBOUNCE_CYCLES`.
- **Glitch rejection:** any synchronized pulse shorter than `DEBOUNCE_CYCLES` cycles produces no event, and its counter returns to 0.
- **Commit timing:** `committed` updates at the edge ending the `move_enable` cycle. `direction` is stable across that edge unless a new request is accepted at the same edge.
- **Turn rate:** at most one turn commits per `move_enable`. Requests between steps collapse to the last legal one.
- **`move_enable` with nothing queued:** no change to any state.

## Test plan

1. **Reset:** with `DEBOUNCE_CYCLES`=4, assert `reset`=0 mid-run with `btn_up` bouncing -> `direction`=01, `start`=0, `pending`=0 immediately; no press event within 6 cycles after release if the button stays at 0.
2. **Clean turn:** hold `btn_up` 10 cycles -> `pending`=1 and `direction`=00 exactly 6 edges after first sampling. Then pulse `move_enable` -> `pending`=0, `direction` stays 00, `committed`=00.
3. **Bounce:** toggle `btn_right` high 3 cycles, low 1 cycle, high 2 cycles, then low -> no `pending`, `direction` unchanged, every counter back at 0.
4. **Reversal:** `committed`=01, debounced press of left -> `pending`=0, `direction`=01. Then press up, then left before any `move_enable` -> `direction`=00 (left rejected). After `move_enable` (`committed`=00), press left -> `direction`=11.
5. **Simultaneous events:** up and down rise in the same cycle -> up wins (`direction`=00). A press of down landing in the same cycle as a `move_enable` that commits 00 -> discarded as a reversal.
6. **Start:** hold `btn_start` 20 cycles -> exactly one `start` pulse, 6 edges after first sampling. Release and press again -> a second single pulse.
